// File: rtl/hd44780_busy_sequencer.sv
// Command stage for the HD44780U phy: polls the busy flag before every instruction,
// forwards the instruction once the LCD is idle, and returns read data or a timeout error.
module hd44780_busy_sequencer #(
  parameter int DATA_WIDTH             = 8,
  parameter int INSTR_WIDTH            = 10,
  parameter int CHECK_BUSY_ERROR_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [CHECK_BUSY_ERROR_WIDTH-1:0] poll_limit_i,
  input  logic                              err_clear_i,
  input  logic [INSTR_WIDTH-1:0]            cmd_instr_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  output logic [DATA_WIDTH-1:0]             rsp_data_o,
  output logic                              rsp_err_o,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic                              busy_timeout_o,
  output logic [INSTR_WIDTH-1:0]            phy_instr_o,
  output logic                              phy_valid_o,
  input  logic                              phy_ready_i,
  input  logic [DATA_WIDTH-1:0]             phy_rdata_i
);

  localparam int RS_BIT  = INSTR_WIDTH - 1;
  localparam int RWB_BIT = INSTR_WIDTH - 2;
  localparam int CW      = CHECK_BUSY_ERROR_WIDTH;
  localparam logic [INSTR_WIDTH-1:0] STATUS_READ = {1'b0, 1'b1, {(INSTR_WIDTH-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_REQ, S_POLL_WAIT, S_CMD_REQ, S_CMD_WAIT, S_TIMEOUT, S_RSP
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CW-1:0]          poll_cnt_q, poll_cnt_d;
  logic                   phy_valid_q, phy_valid_d;
  logic [INSTR_WIDTH-1:0] phy_instr_q, phy_instr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy_timeout_q, busy_timeout_d;

  logic          is_status_cmd;
  logic          poll_hit;
  logic [CW-1:0] poll_cnt_inc;

  assign is_status_cmd = !cmd_instr_i[RS_BIT] && cmd_instr_i[RWB_BIT];
  // Compare in CW+1 bits so an all-ones limit is reachable without wrap-around.
  assign poll_hit      = (poll_limit_i != '0) &&
                         (({1'b0, poll_cnt_q} + (CW+1)'(1)) == {1'b0, poll_limit_i});
  assign poll_cnt_inc  = (&poll_cnt_q) ? poll_cnt_q : poll_cnt_q + CW'(1);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    poll_cnt_d     = poll_cnt_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    busy_timeout_d = err_clear_i ? 1'b0 : busy_timeout_q;

    unique case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        instr_d    = cmd_instr_i;
        poll_cnt_d = '0;
        state_d    = is_status_cmd ? S_CMD_REQ : S_POLL_REQ;
      end
      S_POLL_REQ: if (phy_valid_q && phy_ready_i) state_d = S_POLL_WAIT;
      S_POLL_WAIT: if (phy_ready_i) begin
        if (!phy_rdata_i[DATA_WIDTH-1]) begin
          state_d = S_CMD_REQ;
        end else begin
          poll_cnt_d = poll_cnt_inc;
          state_d    = poll_hit ? S_TIMEOUT : S_POLL_REQ;
        end
      end
      S_CMD_REQ: if (phy_valid_q && phy_ready_i) begin
        state_d = instr_q[RWB_BIT] ? S_CMD_WAIT : S_IDLE;
      end
      S_CMD_WAIT: if (phy_ready_i) begin
        rsp_data_d = phy_rdata_i;
        rsp_err_d  = 1'b0;
        state_d    = S_RSP;
      end
      S_TIMEOUT: begin
        busy_timeout_d = 1'b1;
        if (instr_q[RWB_BIT]) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RSP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RSP: if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Phy and response outputs are registered decodes of the next state.
    phy_valid_d = (state_d == S_POLL_REQ) || (state_d == S_CMD_REQ);
    phy_instr_d = (state_d == S_POLL_REQ) ? STATUS_READ :
                  (state_d == S_CMD_REQ)  ? instr_d     : '0;
    rsp_valid_d = (state_d == S_RSP);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      poll_cnt_q     <= '0;
      phy_valid_q    <= 1'b0;
      phy_instr_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      busy_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      poll_cnt_q     <= poll_cnt_d;
      phy_valid_q    <= phy_valid_d;
      phy_instr_q    <= phy_instr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      busy_timeout_q <= busy_timeout_d;
    end
  end

  // Held low while reset is asserted so every output reads 0 during reset.
  assign cmd_ready_o    = (state_q == S_IDLE) && !rst_i;
  assign phy_valid_o    = phy_valid_q;
  assign phy_instr_o    = phy_instr_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign busy_timeout_o = busy_timeout_q;

endmodule
